// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and fetch FSM state encoding.
// Also imported by the control unit, so encodings here must stay stable.
package cpu_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 16;
  localparam int OPCODE_W    = 6;

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_EXEC   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC mux: pc+1 (wrapping) or jump target, on load_en.
// Updates on the edge after load_en; holds otherwise. No backpressure.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic            s_inc,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  // Increment wraps naturally at 2^PC_W; no overflow indication is wanted.
  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = s_inc ? (pc_q + PC_W'(1)) : target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch FSM (FETCH/EXEC/HALTED) with instruction register; fetch waits on imem_ack,
// EXEC is one cycle, halt freezes pc/IR after the current instruction.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  input  logic               s_inc,
  input  logic               halt,
  output logic [INSTR_W-1:0] instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc
);

  logic [1:0]         state_d;
  logic [1:0]         state_q;
  logic [INSTR_W-1:0] ir_d;
  logic [INSTR_W-1:0] ir_q;
  logic               pc_load;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_load = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_load = 1'b1;
        state_d = halt ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: begin
        if (!halt) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  pc_reg #(
    .PC_W (PC_W)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .load_en (pc_load),
    .s_inc   (s_inc),
    .target  (ir_q[PC_W-1:0]),
    .pc      (pc)
  );

  // Reset state is FETCH, so the request is gated by reset to stay low while held.
  assign imem_req    = reset && (state_q == ST_FETCH);
  assign instr_valid = reset && (state_q == ST_EXEC);
  assign imem_addr   = pc;
  assign instr       = ir_q;
  assign opcode      = ir_q[INSTR_W-1:INSTR_W-OPCODE_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random instruction streams checked
// against an instruction-level model of pc/IR sequencing.
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 16;

  logic               clk;
  logic               reset;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;
  logic               s_inc;
  logic               halt;
  logic [INSTR_W-1:0] instr;
  logic [5:0]         opcode;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;

  int checks   = 0;
  int failures = 0;

  logic [PC_W-1:0]    model_pc;
  logic [INSTR_W-1:0] model_ir;

  fetch_unit #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .s_inc       (s_inc),
    .halt        (halt),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: fetch with dly wait cycles, one EXEC, optional halt for hold cycles.
  task automatic run_instr(input logic [INSTR_W-1:0] rd, input int dly,
                           input logic inc, input logic hlt, input int hold);
    for (int i = 0; i <= dly; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== model_pc || pc !== model_pc) begin
        failures++;
        $display("FAIL fetch_req cyc=%0d req=%b addr=%h pc=%h expected req=1 addr=pc=%h",
                 i, imem_req, imem_addr, pc, model_pc);
      end
      checks++;
      if (instr_valid !== 1'b0 || instr !== model_ir) begin
        failures++;
        $display("FAIL fetch_hold cyc=%0d valid=%b instr=%h expected valid=0 instr=%h",
                 i, instr_valid, instr, model_ir);
      end
      imem_ack   = (i == dly);
      imem_rdata = (i == dly) ? rd : INSTR_W'($urandom);
      s_inc      = 1'($urandom);
      halt       = 1'($urandom);
      step();
    end
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== rd || opcode !== rd[15:10]
        || pc !== model_pc) begin
      failures++;
      $display("FAIL exec valid=%b req=%b instr=%h opc=%h pc=%h expected 1 0 %h %h %h",
               instr_valid, imem_req, instr, opcode, pc, rd, rd[15:10], model_pc);
    end
    // A stray ack during EXEC must not disturb IR.
    imem_ack   = 1'b1;
    imem_rdata = ~rd;
    s_inc      = inc;
    halt       = hlt;
    step();
    model_ir = rd;
    model_pc = inc ? PC_W'((int'(model_pc) + 1) % (1 << PC_W)) : rd[PC_W-1:0];
    if (hlt) begin
      for (int h = 0; h < hold; h++) begin
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== model_pc || instr !== model_ir) begin
          failures++;
          $display("FAIL halted h=%0d req=%b valid=%b pc=%h instr=%h expected 0 0 %h %h",
                   h, imem_req, instr_valid, pc, instr, model_pc, model_ir);
        end
        imem_ack   = 1'($urandom);
        imem_rdata = INSTR_W'($urandom);
        s_inc      = 1'($urandom);
        halt       = (h < hold - 1);
        step();
      end
    end
    imem_ack = 1'b0;
    halt     = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    s_inc      = 1'b0;
    halt       = 1'b0;
    step();
    step();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== '0 || instr !== '0 || opcode !== '0) begin
      failures++;
      $display("FAIL reset_state req=%b valid=%b pc=%h instr=%h opc=%h expected all 0",
               imem_req, instr_valid, pc, instr, opcode);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== '0) begin
      failures++;
      $display("FAIL reset_release req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
    model_pc = '0;
    model_ir = '0;
  endtask

  task automatic test_alu_inc();
    run_instr(16'h0005, 0, 1'b1, 1'b0, 1);
    checks++;
    if (pc !== 10'd1 || imem_addr !== 10'd1) begin
      failures++;
      $display("FAIL alu_inc pc=%h addr=%h expected 001", pc, imem_addr);
    end
  endtask

  task automatic test_jump();
    run_instr(16'hA41F, 0, 1'b0, 1'b0, 1);
    checks++;
    if (imem_addr !== 10'h01F || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL jump addr=%h req=%b expected addr=01F req=1", imem_addr, imem_req);
    end
  endtask

  task automatic test_delayed_ack();
    run_instr(16'h1234, 3, 1'b1, 1'b0, 1);
    checks++;
    if (pc !== 10'h020) begin
      failures++;
      $display("FAIL delayed_ack pc=%h expected 020", pc);
    end
  endtask

  task automatic test_wrap();
    run_instr(16'h07FF, 1, 1'b0, 1'b0, 1);
    run_instr(16'h4C00, 0, 1'b1, 1'b0, 1);
    checks++;
    if (pc !== 10'h000 || imem_addr !== 10'h000) begin
      failures++;
      $display("FAIL wrap pc=%h addr=%h expected 000", pc, imem_addr);
    end
  endtask

  task automatic test_halt();
    run_instr(16'h2804, 0, 1'b0, 1'b0, 1);
    run_instr(16'h8888, 0, 1'b1, 1'b1, 3);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd5) begin
      failures++;
      $display("FAIL halt_resume req=%b addr=%h expected req=1 addr=005", imem_req, imem_addr);
    end
  endtask

  task automatic test_async_reset();
    run_instr(16'h3C07, 0, 1'b0, 1'b0, 1);
    step();
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd7) begin
      failures++;
      $display("FAIL pre_reset req=%b addr=%h expected req=1 addr=007", imem_req, imem_addr);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr !== '0 || pc !== '0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset req=%b instr=%h pc=%h valid=%b expected 0 0 0 0",
               imem_req, instr, pc, instr_valid);
    end
    imem_ack   = 1'b1;
    imem_rdata = 16'hFFFF;
    step();
    step();
    imem_ack = 1'b0;
    checks++;
    if (instr !== '0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack instr=%h req=%b valid=%b expected 0 0 0", instr, imem_req, instr_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== '0) begin
      failures++;
      $display("FAIL post_reset req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
    model_pc = '0;
    model_ir = '0;
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      run_instr(INSTR_W'($urandom), 0, 1'($urandom), 1'b0, 1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      run_instr(INSTR_W'($urandom), $urandom_range(0, 3), 1'($urandom),
                ($urandom_range(0, 3) == 0), $urandom_range(1, 3));
    end
  endtask

  initial begin
    test_reset();
    test_alu_inc();
    test_jump();
    test_delayed_ack();
    test_wrap();
    test_halt();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter and instruction-address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width; opcode is [INSTR_W-1:INSTR_W-6], jump target is [PC_W-1:0].
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  output  PC_W  read address, equal to pc.
REQ-007 SHALL have port imem_rdata  input  INSTR_W  read data, valid when imem_ack=1.
REQ-008 SHALL have port imem_ack  input  1  read-complete strobe.
REQ-009 SHALL have port s_inc  input  1  from control unit; 1 = pc+1, 0 = take jump target.
REQ-010 SHALL have port halt  input  1  request to freeze after the current instruction.
REQ-011 SHALL have port instr  output  INSTR_W  registered instruction (IR).
REQ-012 SHALL have port opcode  output  6  IR opcode field, fed to the control unit.
REQ-013 SHALL have port instr_valid  output  1  high exactly in EXEC; qualifies control-unit write enables.
REQ-014 SHALL have port pc  output  PC_W  current program counter.

Function
REQ-015 SHALL implement FSM states FETCH, EXEC, HALTED.
REQ-016 In FETCH, imem_req SHALL be 1 and imem_addr SHALL hold pc stable until imem_ack.
REQ-017 On imem_ack=1 in FETCH, IR SHALL load imem_rdata and the next state SHALL be EXEC; min fetch latency 1 cycle (ack in first request cycle).
REQ-018 imem_ack outside FETCH SHALL be ignored; IR and state unchanged.
REQ-019 EXEC SHALL last exactly one cycle; instr_valid=1, imem_req=0.
REQ-020 At end of EXEC, pc SHALL become pc+1 modulo 2^PC_W when s_inc=1, else IR[PC_W-1:0].
REQ-021 From EXEC, next state SHALL be HALTED if halt=1, else FETCH; pc update of REQ-020 occurs either way.
REQ-022 In HALTED, imem_req=0, instr_valid=0, pc and IR frozen; halt=0 SHALL move to FETCH next cycle.
REQ-023 halt SHALL be sampled only in EXEC and HALTED.
REQ-024 pc wrap: pc=2^PC_W-1 with s_inc=1 SHALL yield pc=0, no flag.
REQ-025 opcode SHALL equal IR[INSTR_W-1:INSTR_W-6] combinationally.

Reset
REQ-026 reset=0 SHALL immediately force state=FETCH, pc=0, IR=0, regardless of clk.
REQ-027 During reset imem_req and instr_valid SHALL be 0; a fetch in flight SHALL be abandoned, its ack ignored.
REQ-028 After reset release, first rising edge SHALL see imem_req=1, imem_addr=0.

Structure
REQ-029 State encoding and default PC_W/INSTR_W SHALL live in shared package cpu_pkg, also used by the control unit.
REQ-030 PC register with next-PC mux SHALL be sub-module pc_reg (inputs s_inc, target, load enable); FSM and IR stay in fetch_unit.

Verification
REQ-031 Reset, ack in first cycle, rdata=0x0005 (ALU op), s_inc=1 -> EXEC one cycle with opcode=0x00, then pc=1, imem_addr=1.
REQ-032 rdata=0xA41F (opcode 101001, target 0x01F), s_inc=0 in EXEC -> next FETCH with imem_addr=0x01F.
REQ-033 ack delayed 3 cycles -> imem_req high 4 cycles, imem_addr constant, instr_valid 0 throughout, IR updates only on ack.
REQ-034 pc=0x3FF, s_inc=1 -> pc=0x000 next fetch.
REQ-035 halt=1 during EXEC at pc=4 -> HALTED, pc=5 frozen, no req; halt=0 -> FETCH at 5 next cycle.
REQ-036 reset=0 asserted mid-FETCH at pc=7, then ack pulsed during reset -> imem_req drops asynchronously, IR=0; after release fetch from address 0.
